// File: rtl/muxn_stream_arb.sv
// N-channel registered stream multiplexer with a valid/ready handshake; grant by external select (MODE 0) or round-robin (MODE 1).
// Optional macro MUXN_SKID_EN adds a one-entry skid register so that in_ready depends only on registered state.
module muxn_stream_arb #(
    parameter int N     = 4,
    parameter int WIDTH = 32,
    parameter int MODE  = 0,
    localparam int SELW = (N > 1) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [SELW-1:0]    sel,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_chan,
    output logic               out_valid,
    input  logic               out_ready
);

    localparam logic [SELW:0] N_W = (SELW + 1)'(N);

    logic [SELW-1:0]  ptr_r;
    logic [SELW:0]    rr_s;
    logic             grant_vld_s;
    logic [SELW-1:0]  grant_s;
    logic [WIDTH-1:0] grant_data_s;
    logic             ready_s;
    logic             load_s;
    logic             xfer_s;
    logic [WIDTH-1:0] out_data_r;
    logic [SELW-1:0]  out_chan_r;
    logic             out_valid_r;
`ifdef MUXN_SKID_EN
    logic             skid_full_r;
    logic [WIDTH-1:0] skid_data_r;
    logic [SELW-1:0]  skid_chan_r;
`endif

    // Returns {found, channel}: first valid channel after 'last', wrapping N-1 -> 0.
    function automatic logic [SELW:0] rr_pick(input logic [N-1:0] valid, input logic [SELW-1:0] last);
        logic [SELW:0] pick;
        logic [SELW:0] c;
        pick = '0;
        for (int k = 1; k <= N; k++) begin
            c = {1'b0, last} + (SELW + 1)'(k);
            c = (c >= N_W) ? (c - N_W) : c;
            if (!pick[SELW] && valid[c[SELW-1:0]]) begin
                pick = {1'b1, c[SELW-1:0]};
            end
        end
        return pick;
    endfunction

    assign rr_s   = rr_pick(in_valid, ptr_r);
    assign load_s = !out_valid_r || out_ready;

    // Grant selection: external select or round-robin search.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_s     = '0;
        if (MODE == 0) begin
            if ({1'b0, sel} < N_W) begin
                grant_vld_s = 1'b1;
                grant_s     = sel;
            end else begin
                grant_vld_s = 1'b0;
                grant_s     = '0;
            end
        end else begin
            grant_vld_s = rr_s[SELW];
            grant_s     = rr_s[SELW-1:0];
        end
    end

    // Ready for the granted channel; the skid variant cuts the path from out_ready.
    always_comb begin
        ready_s = 1'b0;
`ifdef MUXN_SKID_EN
        ready_s = !skid_full_r;
`else
        ready_s = load_s;
`endif
    end

    // One-hot in_ready, transfer strobe and data select for the granted channel.
    always_comb begin
        in_ready     = '0;
        grant_data_s = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_s == SELW'(i)) begin
                in_ready[i]  = !reset && grant_vld_s && ready_s;
                grant_data_s = in_data[i*WIDTH +: WIDTH];
            end else begin
                in_ready[i]  = 1'b0;
            end
        end
        xfer_s = |(in_valid & in_ready);
    end

    // Round-robin last-grant pointer; moves only on a transfer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_r <= SELW'(N - 1);
        end else if (xfer_s) begin
            ptr_r <= grant_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Output stage (and skid entry) with hold under backpressure.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_chan_r  <= '0;
`ifdef MUXN_SKID_EN
            skid_full_r <= 1'b0;
            skid_data_r <= '0;
            skid_chan_r <= '0;
`endif
        end else if (load_s) begin
`ifdef MUXN_SKID_EN
            if (skid_full_r) begin
                out_valid_r <= 1'b1;
                out_data_r  <= skid_data_r;
                out_chan_r  <= skid_chan_r;
                skid_full_r <= 1'b0;
            end else
`endif
            if (xfer_s) begin
                out_valid_r <= 1'b1;
                out_data_r  <= grant_data_s;
                out_chan_r  <= grant_s;
            end else begin
                out_valid_r <= 1'b0;
            end
        end else begin
`ifdef MUXN_SKID_EN
            // Stalled output: a word accepted now parks in the skid entry.
            if (xfer_s) begin
                skid_full_r <= 1'b1;
                skid_data_r <= grant_data_s;
                skid_chan_r <= grant_s;
            end
`endif
            out_valid_r <= out_valid_r;
        end
    end

    assign out_data  = out_data_r;
    assign out_chan  = out_chan_r;
    assign out_valid = out_valid_r;

endmodule
